// File: rtl/gb_cart_pkg.sv
// rtl/gb_cart_pkg.sv - shared types and constants for the cartridge bank controller
`timescale 1ns/1ps
package gb_cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Register regions: 3-bit codes compare against A[15:13], 4-bit codes against A[15:12]
    localparam logic [2:0] REG_RAMEN    = 3'b000;
    localparam logic [3:0] REG_ROMLO    = 4'h2;
    localparam logic [3:0] REG_ROMHI    = 4'h3;
    localparam logic [2:0] REG_RAMBANK  = 3'b010;
    localparam logic [2:0] RAM_BASE     = 3'b101;

    localparam logic [3:0] RAM_EN_MAGIC = 4'hA;

    localparam logic [8:0] ROM_BANK_RST = 9'd1;
    localparam logic [7:0] RAM_BANK_RST = 8'd0;

    // A cart RAM cycle needs the A000-BFFF window, chip select and the enable latch
    function automatic logic ram_hit(input logic [15:0] a, input logic ncs, input logic en);
        return (a[15:13] == RAM_BASE) && !ncs && en;
    endfunction

endpackage

// File: rtl/gb_mbc_ctrl_if.sv
// rtl/gb_mbc_ctrl_if.sv - memory-side bus between bank controller and ROM/RAM arrays
`timescale 1ns/1ps
interface gb_mbc_ctrl_if #(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4
);
    logic [ROM_BANK_BITS+13:0] rom_addr;
    logic                      rom_rd;
    logic [7:0]                rom_rdata;
    logic [RAM_BANK_BITS+12:0] ram_addr;
    logic                      ram_rd;
    logic                      ram_wr;
    logic [7:0]                ram_wdata;
    logic [7:0]                ram_rdata;

    modport master (
        output rom_addr, rom_rd, ram_addr, ram_rd, ram_wr, ram_wdata,
        input  rom_rdata, ram_rdata
    );

    modport slave (
        input  rom_addr, rom_rd, ram_addr, ram_rd, ram_wr, ram_wdata,
        output rom_rdata, ram_rdata
    );
endinterface

// File: rtl/gb_sync.sv
// rtl/gb_sync.sv - multi-stage flop synchroniser for asynchronous cartridge pins
`timescale 1ns/1ps
module gb_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [STAGES];

    // Shift pins through STAGES flops; reset parks strobes at their idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];
endmodule

// File: rtl/gb_mbc_ctrl.sv
// rtl/gb_mbc_ctrl.sv - MBC5-style bank controller and cartridge bus-cycle sequencer
`timescale 1ns/1ps
import gb_cart_pkg::*;
module gb_mbc_ctrl #(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          address,
    input  logic [7:0]           data_in,
    input  logic                 nWR,
    input  logic                 nRD,
    input  logic                 nCS,
    gb_mbc_ctrl_if.master        mem,
    output logic [7:0]           data_out,
    output logic                 data_oe
);
    logic [15:0] addr_s;
    logic [7:0]  data_s;
    logic        nrd_s, nwr_s, ncs_s;

    // One synchroniser for every pin keeps address, data and strobes aligned
    gb_sync #(
        .WIDTH   (27),
        .STAGES  (SYNC_STAGES),
        .RST_VAL ({24'h0, 3'b111})
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({address, data_in, nRD, nWR, nCS}),
        .q   ({addr_s, data_s, nrd_s, nwr_s, ncs_s})
    );

    state_t                   state, state_n;
    logic                     rd_go, wr_cap, wr_commit;
    logic [15:0]              rd_addr, wr_addr;
    logic [7:0]               wr_data;
    logic                     wr_ncs;
    logic [8:0]               rom_bank;
    logic [RAM_BANK_BITS-1:0] ram_bank;
    logic                     ram_en;
    logic                     rd_pend, rd_src_ram;
    logic                     rd_rom, rd_ram;
    logic [ROM_BANK_BITS-1:0] rd_bank;

    assign rd_rom  = !addr_s[15];
    assign rd_ram  = ram_hit(addr_s, ncs_s, ram_en);
    assign rd_bank = addr_s[14] ? rom_bank[ROM_BANK_BITS-1:0] : '0;

    // Bus-cycle state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state; write has priority over read whenever nWR is low
    always_comb begin
        state_n   = state;
        rd_go     = 1'b0;
        wr_cap    = 1'b0;
        wr_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!nwr_s) begin
                    state_n = ST_WRITE;
                    wr_cap  = 1'b1;
                end else if (!nrd_s) begin
                    state_n = ST_READ;
                    rd_go   = 1'b1;
                end
            end
            ST_READ: begin
                if (!nwr_s) begin
                    state_n = ST_WRITE;
                    wr_cap  = 1'b1;
                end else if (nrd_s) begin
                    state_n = ST_IDLE;
                end else if (addr_s != rd_addr) begin
                    rd_go = 1'b1;
                end
            end
            ST_WRITE: begin
                if (nwr_s) begin
                    state_n   = ST_COMMIT;
                    wr_commit = 1'b1;
                end else begin
                    wr_cap = 1'b1;
                end
            end
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Strobes, bank registers, write capture and the pin-side read data path.
    // The commit is registered on the WRITE->COMMIT edge so ram_wr is high during COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem.rom_addr  <= '0;
            mem.rom_rd    <= 1'b0;
            mem.ram_addr  <= '0;
            mem.ram_rd    <= 1'b0;
            mem.ram_wr    <= 1'b0;
            mem.ram_wdata <= '0;
            rd_addr       <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_ncs        <= 1'b1;
            rom_bank      <= ROM_BANK_RST;
            ram_bank      <= RAM_BANK_RST[RAM_BANK_BITS-1:0];
            ram_en        <= 1'b0;
            rd_pend       <= 1'b0;
            rd_src_ram    <= 1'b0;
            data_out      <= '0;
            data_oe       <= 1'b0;
        end else begin
            mem.rom_rd <= 1'b0;
            mem.ram_rd <= 1'b0;
            mem.ram_wr <= 1'b0;
            rd_pend    <= mem.rom_rd | mem.ram_rd;
            rd_src_ram <= mem.ram_rd;

            if (rd_go) begin
                rd_addr    <= addr_s;
                mem.rom_rd <= rd_rom;
                mem.ram_rd <= rd_ram;
                if (rd_rom) mem.rom_addr <= {rd_bank, addr_s[13:0]};
                if (rd_ram) mem.ram_addr <= {ram_bank, addr_s[12:0]};
            end

            if (wr_cap) begin
                wr_addr <= addr_s;
                wr_data <= data_s;
                wr_ncs  <= ncs_s;
            end

            if (wr_commit) begin
                if (!wr_addr[15]) begin
                    if (wr_addr[15:13] == REG_RAMEN)
                        ram_en <= (wr_data[3:0] == RAM_EN_MAGIC);
                    else if (wr_addr[15:12] == REG_ROMLO)
                        rom_bank[7:0] <= wr_data;
                    else if (wr_addr[15:12] == REG_ROMHI && ROM_BANK_BITS >= 9)
                        rom_bank[8] <= wr_data[0];
                    else if (wr_addr[15:13] == REG_RAMBANK)
                        ram_bank <= wr_data[RAM_BANK_BITS-1:0];
                end else if (ram_hit(wr_addr, wr_ncs, ram_en)) begin
                    mem.ram_wr    <= 1'b1;
                    mem.ram_addr  <= {ram_bank, wr_addr[12:0]};
                    mem.ram_wdata <= wr_data;
                end
            end

            if (state_n != ST_READ) begin
                data_oe <= 1'b0;
            end else if (rd_go && !(rd_rom || rd_ram)) begin
                data_oe <= 1'b0;
            end else if (rd_pend) begin
                data_out <= rd_src_ram ? mem.ram_rdata : mem.rom_rdata;
                data_oe  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gb_mbc_ctrl.sv
// tb/tb_gb_mbc_ctrl.sv - directed self-checking bench for gb_mbc_ctrl
`timescale 1ns/1ps
module tb_gb_mbc_ctrl;
    localparam int SYNC = 2;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        nWR, nRD, nCS;
    logic [7:0]  data_out;
    logic        data_oe;

    gb_mbc_ctrl_if #(.ROM_BANK_BITS(9), .RAM_BANK_BITS(4)) mem_if ();

    gb_mbc_ctrl #(
        .ROM_BANK_BITS (9),
        .RAM_BANK_BITS (4),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .data_in  (data_in),
        .nWR      (nWR),
        .nRD      (nRD),
        .nCS      (nCS),
        .mem      (mem_if),
        .data_out (data_out),
        .data_oe  (data_oe)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Memory models: data one cycle after the strobe, pattern derived from the address
    always @(posedge clk) begin
        if (rst) begin
            mem_if.rom_rdata <= 8'h00;
            mem_if.ram_rdata <= 8'h00;
        end else begin
            if (mem_if.rom_rd) mem_if.rom_rdata <= mem_if.rom_addr[7:0] ^ 8'h3C;
            if (mem_if.ram_rd) mem_if.ram_rdata <= mem_if.ram_addr[7:0] ^ 8'h96;
        end
    end

    int          rom_rd_cnt = 0, ram_rd_cnt = 0, ram_wr_cnt = 0, wide_cnt = 0;
    logic        prev_strobe = 1'b0;
    logic [16:0] last_waddr = '0;
    logic [7:0]  last_wdata = '0;

    // Strobe observers
    always @(posedge clk) begin
        if (mem_if.rom_rd) rom_rd_cnt <= rom_rd_cnt + 1;
        if (mem_if.ram_rd) ram_rd_cnt <= ram_rd_cnt + 1;
        if (mem_if.ram_wr) begin
            ram_wr_cnt <= ram_wr_cnt + 1;
            last_waddr <= mem_if.ram_addr;
            last_wdata <= mem_if.ram_wdata;
        end
        if (prev_strobe && (mem_if.rom_rd || mem_if.ram_rd || mem_if.ram_wr))
            wide_cnt <= wide_cnt + 1;
        prev_strobe <= mem_if.rom_rd | mem_if.ram_rd | mem_if.ram_wr;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic cs_for(input logic [15:0] a);
        return !(a >= 16'hA000);
    endfunction

    // Start a read and return the cycles until data_oe rises (20 if it never does)
    task automatic do_read(input logic [15:0] a, output int lat);
        address = a;
        nCS     = cs_for(a);
        nRD     = 1'b0;
        lat     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (data_oe) break;
        end
    endtask

    task automatic end_read(output int lat);
        nRD = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (!data_oe) break;
        end
        repeat (3) tick();
        nCS = 1'b1;
    endtask

    // Full write cycle; wlat is the cycle after nWR rises at which ram_wr shows (0 if none)
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int wlat);
        address = a;
        data_in = d;
        nCS     = cs_for(a);
        nWR     = 1'b0;
        repeat (4) tick();
        nWR  = 1'b1;
        wlat = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (mem_if.ram_wr && wlat == 0) wlat = i;
        end
        nCS = 1'b1;
    endtask

    int lat, lat2, wl, c0, c1;
    logic [7:0] exp_b2b [3];

    initial begin
        exp_b2b[0] = 8'h3C; exp_b2b[1] = 8'h3D; exp_b2b[2] = 8'h3E;
        address = '0; data_in = '0; nRD = 1'b1; nWR = 1'b1; nCS = 1'b1; rst = 1'b1;
        repeat (4) tick();
        check("rst_data_oe", data_oe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_rom_rd", mem_if.rom_rd, 0);
        check("rst_ram_wr", mem_if.ram_wr, 0);
        check("rst_rom_addr", mem_if.rom_addr, 0);
        check("rst_ram_addr", mem_if.ram_addr, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Reset bank is 1
        c0 = rom_rd_cnt;
        do_read(16'h4000, lat);
        check("rd4000_lat", lat, SYNC + 3);
        check("rd4000_addr", mem_if.rom_addr, 32'h004000);
        check("rd4000_data", data_out, 8'h3C);
        end_read(lat2);
        check("oe_drop_lat", lat2, SYNC + 1);
        check("rd4000_pulses", rom_rd_cnt - c0, 1);

        // Nine-bit bank select
        do_write(16'h2000, 8'h05, wl);
        do_write(16'h3000, 8'h01, wl);
        do_read(16'h7FFF, lat);
        check("rd7fff_addr", mem_if.rom_addr, 32'h417FFF);
        check("rd7fff_data", data_out, 8'hC3);
        end_read(lat2);

        // Bank 0 stays bank 0
        do_write(16'h3000, 8'h00, wl);
        do_write(16'h2000, 8'h00, wl);
        do_read(16'h4123, lat);
        check("bank0_addr", mem_if.rom_addr, 32'h000123);
        check("bank0_data", data_out, 8'h1F);
        end_read(lat2);

        // RAM disabled: unmapped read
        c0 = ram_rd_cnt; c1 = rom_rd_cnt;
        do_read(16'hA000, lat);
        check("ramoff_oe", data_oe, 0);
        check("ramoff_ram_rd", ram_rd_cnt - c0, 0);
        check("ramoff_rom_rd", rom_rd_cnt - c1, 0);
        end_read(lat2);

        // Enable RAM, select bank 3, write and read back
        do_write(16'h0000, 8'h0A, wl);
        do_write(16'h4000, 8'h03, wl);
        c0 = ram_wr_cnt;
        do_write(16'hA123, 8'h5C, wl);
        check("ramwr_lat", wl, SYNC + 1);
        check("ramwr_count", ram_wr_cnt - c0, 1);
        check("ramwr_addr", last_waddr, 32'h6123);
        check("ramwr_data", last_wdata, 8'h5C);
        c0 = ram_rd_cnt;
        do_read(16'hA123, lat);
        check("ramrd_oe", data_oe, 1);
        check("ramrd_addr", mem_if.ram_addr, 32'h6123);
        check("ramrd_data", data_out, 8'hB5);
        check("ramrd_pulses", ram_rd_cnt - c0, 1);
        end_read(lat2);

        // nRD held low across stepping addresses
        c0 = rom_rd_cnt;
        nCS = 1'b1;
        nRD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            address = 16'h0100 + 16'(i);
            repeat (6) tick();
            check("b2b_data", data_out, exp_b2b[i]);
            check("b2b_oe", data_oe, 1);
        end
        check("b2b_pulses", rom_rd_cnt - c0, 3);
        end_read(lat2);

        // nWR drops while a read is driving the pins
        do_read(16'h2000, lat);
        check("rw_pre_oe", data_oe, 1);
        data_in = 8'h07;
        nWR = 1'b0;
        lat2 = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat2++;
            if (!data_oe) break;
        end
        check("rw_oe_drop", lat2, SYNC + 1);
        repeat (3) tick();
        nWR = 1'b1;
        nRD = 1'b1;
        repeat (6) tick();
        do_read(16'h4000, lat);
        check("rw_commit_addr", mem_if.rom_addr, 32'h01C000);
        end_read(lat2);

        // Reset during a pending write discards it and restores bank registers
        address = 16'h4000;
        data_in = 8'h09;
        nWR = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rstwr_oe", data_oe, 0);
        check("rstwr_ram_wr", mem_if.ram_wr, 0);
        nWR = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        repeat (2) tick();
        c0 = ram_rd_cnt;
        do_read(16'hA123, lat);
        check("rstwr_ramen", ram_rd_cnt - c0, 0);
        check("rstwr_ram_oe", data_oe, 0);
        end_read(lat2);
        do_read(16'h4000, lat);
        check("rstwr_rombank", mem_if.rom_addr, 32'h004000);
        end_read(lat2);
        do_write(16'h0000, 8'h0A, wl);
        do_read(16'hA001, lat);
        check("rstwr_rambank", mem_if.ram_addr, 32'h0001);
        check("rstwr_ramdata", data_out, 8'h97);
        end_read(lat2);

        check("strobe_width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
